// File: rtl/cic_comb_decim_if.sv
// Sample and result handshake bundle for the CIC comb decimator.
// Driver side uses master; the comb block uses slave.
interface cic_comb_decim_if #(
   parameter int WIDTH  = 19,
   parameter int RATE_W = 8,
   parameter int OUT_W  = 16
);
   logic [WIDTH-1:0]  in;
   logic              in_valid;
   logic [RATE_W-1:0] rate;
   logic [OUT_W-1:0]  out;
   logic              out_valid;
   logic              out_ready;
   logic              overrun;

   modport master (
      output in, in_valid, rate, out_ready,
      input  out, out_valid, overrun
   );

   modport slave (
      input  in, in_valid, rate, out_ready,
      output out, out_valid, overrun
   );
endinterface

// File: rtl/cic_comb_decim.sv
// Decimating CIC comb section: runtime ratio, STAGES combs, registered output.
// Define CIC_COMB_ROUND_EN for round-half-up scaling with positive saturation.
module cic_comb_decim #(
   parameter int WIDTH  = 19,
   parameter int STAGES = 3,
   parameter int RATE_W = 8,
   parameter int OUT_W  = 16
) (
   input logic             clk,
   input logic             rst,
   cic_comb_decim_if.slave bus
);
   localparam logic [RATE_W-1:0] ONE = RATE_W'(1);

   logic              armed;
   logic [RATE_W-1:0] phase;
   logic [RATE_W-1:0] r_lat;
   logic [RATE_W-1:0] rate_map;
   logic [RATE_W-1:0] r_now;
   logic              dec;

   logic [WIDTH-1:0]  x [STAGES+1];
   logic [WIDTH-1:0]  d [STAGES];
   logic [STAGES:0]   v;
   logic [OUT_W-1:0]  scaled;

   assign rate_map = (bus.rate == '0) ? ONE : bus.rate;
   // Before the first edge after reset the ratio comes straight from rate.
   assign r_now    = armed ? r_lat : rate_map;
   assign dec      = bus.in_valid && (phase == r_now - ONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed <= 1'b0;
         phase <= '0;
         r_lat <= '0;
      end else begin
         if (!armed) begin
            armed <= 1'b1;
            r_lat <= rate_map;
         end
         if (bus.in_valid) begin
            if (dec) begin
               phase <= '0;
               r_lat <= rate_map;
            end else begin
               phase <= phase + ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v <= '0;
         for (int i = 0; i <= STAGES; i++) x[i] <= '0;
         for (int i = 0; i < STAGES; i++)  d[i] <= '0;
      end else begin
         v[0] <= dec;
         if (dec) x[0] <= bus.in;
         // Tokens advance every clock; delays move only with a token.
         for (int k = 1; k <= STAGES; k++) begin
            v[k] <= v[k-1];
            if (v[k-1]) begin
               x[k]   <= x[k-1] - d[k-1];
               d[k-1] <= x[k-1];
            end
         end
      end
   end

`ifdef CIC_COMB_ROUND_EN
   generate
      if (WIDTH > OUT_W) begin : g_rnd
         localparam logic [WIDTH-1:0] HALF =
            WIDTH'(1) << (WIDTH - OUT_W - 1);
         localparam logic [OUT_W-1:0] MAXP =
            {1'b0, {(OUT_W-1){1'b1}}};
         logic [WIDTH-1:0] sum;
         assign sum = x[STAGES] + HALF;
         assign scaled =
            (!x[STAGES][WIDTH-1] && sum[WIDTH-1]) ? MAXP
                                                  : sum[WIDTH-1 -: OUT_W];
      end else begin : g_pass
         assign scaled = x[STAGES][WIDTH-1 -: OUT_W];
      end
   endgenerate
`else
   assign scaled = x[STAGES][WIDTH-1 -: OUT_W];
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
         bus.overrun   <= 1'b0;
      end else begin
         if (v[STAGES]) begin
            bus.out       <= scaled;
            bus.out_valid <= 1'b1;
            if (bus.out_valid && !bus.out_ready) bus.overrun <= 1'b1;
         end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/cic_comb_decim.md
# cic_comb_decim

Decimating comb section of the DDC's CIC decimator. It sits directly after the integrator chain and consumes the 19-bit integrator output at the input sample rate. The block downsamples by a runtime-selected ratio R and runs STAGES cascaded comb (differentiator) stages at the decimated rate. It then scales the result to the output width and presents it on a valid/ready output port.

## Interface
Parameters:
- `WIDTH`, 19, input and internal comb width (must equal integrator width)
- `STAGES`, 3, number of comb stages (1..8), differential delay M = 1
- `RATE_W`, 8, width of decimation ratio input
- `OUT_W`, 16, output width; scaling keeps the top `OUT_W` bits of `WIDTH`

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in`  in  `WIDTH`  integrator output, two's complement, wraps modulo 2^`WIDTH`
- `in_valid`  in  1  `in` carries a sample this cycle
- `rate`  in  `RATE_W`  decimation ratio R; 0 is treated as 1
- `out`  out  `OUT_W`  decimated filter output, signed
- `out_valid`  out  1  `out` holds an unconsumed result
- `out_ready`  in  1  downstream accepts `out` this cycle
- `overrun`  out  1  sticky: a result was overwritten before acceptance

## Operation
- Reset (`rst` low, at any time, including mid-frame): `out`=0, `out_valid`=0, `overrun`=0. The phase counter, latched ratio, all comb delay registers and pipeline valids are also cleared. Recovery is on the first rising `clk` after `rst` goes high.
- Phase counter counts `in_valid` cycles from 0 to R_eff−1, then wraps to 0.
  - R_eff is latched from `rate` (0 maps to 1) at reset release and on every wrap.
  - A change to `rate` mid-frame takes effect only after the current frame completes.
  - Cycles with `in_valid`=0 do not advance the counter or the pipeline.
- Decimation point: an `in_valid` cycle with counter = R_eff−1. It captures `in` into the stage-0 register as a token.
- Comb stage k (1..STAGES), when its input token is valid:
  - y_k = x_k − d_k, with d_k ← x_k.
  - Subtraction is modulo 2^`WIDTH` with no saturation, so integrator wrap cancels exactly.
  - Delay registers update only on tokens.
- Scaling: `out` = y_STAGES[`WIDTH`−1 : `WIDTH`−`OUT_W`], i.e. truncation toward −∞.
- Output handshake:
  - A new result loads `out` and sets `out_valid`.
  - `out_valid` && `out_ready` consumes the result; `out_valid` clears unless a new result loads in the same cycle.
  - New result while `out_valid`=1 and `out_ready`=0: `out` is overwritten and `overrun` is set. `overrun` stays high until reset.
  - New result in the same cycle as an accepting `out_ready`: the new value loads, `out_valid` stays 1, and `overrun` is not set.
- `out_ready` never stalls the comb pipeline; the input side has no backpressure.

## Timing
- Latency: `out_valid` rises exactly STAGES+1 clocks after the edge that accepted the decimation-point sample. This assumes `in_valid` does not gate intermediate stages, because tokens advance every clock once captured.
- Maximum throughput: one result per clock (R_eff = 1).
- First STAGES outputs after reset are the comb transient, derived from zeroed delay registers.
- All outputs are registered; no combinational path from `in` or `out_ready` to any output.

## Configuration
- `CIC_COMB_ROUND_EN` defined: scaling rounds half-up.
  - The block adds 2^(`WIDTH`−`OUT_W`−1) before taking the top bits.
  - A positive result that would wrap saturates to 2^(`OUT_W`−1)−1.
  - When `WIDTH` = `OUT_W`, rounding is a no-op.
- Not defined: plain truncation as above; no saturation logic is instantiated.

## Test plan
- STAGES=3, WIDTH=19, OUT_W=16, rate=4, `in`=64 constant, `in_valid`=1, `out_ready`=1 → `out` sequence 8, −16, 8, 0, 0… with one `out_valid` pulse every 4 clocks, each pulse 4 clocks after its decimation point.
- rate=1, `in` = 1000·k mod 2^19 ramp from k=0, `out_ready`=1 → `out` 0, 125, −125, then 0 continuously, including across the wrap near k=525.
- rate changed 4→5 mid-frame → current frame still completes after 4 samples; subsequent `out_valid` spacing is 5 `in_valid` cycles. rate=0 → a result on every `in_valid`.
- `out_ready`=0 held across two results → `out` shows the second result, `overrun`=1 and sticky. Result arriving with `out_ready`=1 on the same cycle → no overrun.
- `rst` asserted mid-frame with nonzero delay registers → all outputs 0 immediately. After release, constant-64 stimulus reproduces the first-scenario sequence exactly.
- With `CIC_COMB_ROUND_EN`, `in` stepping so y_3 = 0x3FFFC → `out` = 0x7FFF (saturated); without the macro, `out` = 0x7FFF by truncation, and y_3 = 4 gives 1 (rounded) versus 0 (truncated).
